// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state enum, bank ids and bank-select width helper for regfile_banked
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam int BANK_INT = 0;
  localparam int BANK_FP = 1;
  function automatic int bank_bits(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_banked_if.sv
// regfile_banked_if: decode-side write/claim/read bus of regfile_banked; master drives requests, slave returns registered reads and ready
interface regfile_banked_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NBANKS = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = regfile_pkg::bank_bits(NBANKS);
  logic write, regdst, claim;
  logic [BW-1:0] wbank, rbank, claim_bank;
  logic [AW-1:0] rd, rs, rt, claim_addr;
  logic [WIDTH-1:0] busW, busA, busB;
  logic pendA, pendB, ready;
  modport master (
    output write, regdst, wbank, rbank, rd, rs, rt, busW, claim, claim_bank, claim_addr,
    input busA, busB, pendA, pendB, ready
  );
  modport slave (
    input write, regdst, wbank, rbank, rd, rs, rt, busW, claim, claim_bank, claim_addr,
    output busA, busB, pendA, pendB, ready
  );
endinterface

// File: rtl/regfile_bank.sv
// regfile_bank: DEPTH x WIDTH storage plus pending bits; ports clk, clear index, write/claim strobes, two combinational read ports
module regfile_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_idx_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             claim_i,
  input  logic [AW-1:0]    claim_addr_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o,
  output logic             rpend_a_o,
  output logic             rpend_b_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  always_ff @(posedge clk) begin
    if (clr_i) begin
      mem_q[clr_idx_i] <= '0;
      pend_q[clr_idx_i] <= 1'b0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
        pend_q[waddr_i] <= 1'b0;
      end
      if (claim_i) pend_q[claim_addr_i] <= 1'b1;
    end
  end
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rpend_a_o = pend_q[raddr_a_i];
  assign rpend_b_o = pend_q[raddr_b_i];
endmodule

// File: rtl/regfile_banked.sv
// regfile_banked: banked register file with scoreboard, write-through reads and post-reset clear sweep; ports clk, rst, bus (regfile_banked_if.slave)
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NBANKS = 2,
  parameter int ZERO_R0 = 1
) (
  input logic clk,
  input logic rst,
  regfile_banked_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = bank_bits(NBANKS);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, waddr;
  logic run, clr, w_ok, c_ok, r_ok_a, r_ok_b;
  logic hit_wa, hit_wb, hit_ca, hit_cb;
  logic [NBANKS-1:0] we, ce, rpend_a, rpend_b;
  logic [WIDTH-1:0] rdata_a [NBANKS];
  logic [WIDTH-1:0] rdata_b [NBANKS];
  logic [WIDTH-1:0] busa_q, busa_d, busb_q, busb_d;
  logic penda_q, penda_d, pendb_q, pendb_d;
  function automatic logic in_range(logic [BW-1:0] b);
    return int'(b) < NBANKS;
  endfunction
  function automatic logic is_zero(logic [BW-1:0] b, logic [AW-1:0] a);
    return ZERO_R0 != 0 && b == BW'(BANK_INT) && a == '0;
  endfunction
  assign run = state_q == RUN && !rst;
  assign clr = state_q == CLEAR;
  assign cnt_d = clr ? cnt_q + AW'(1) : cnt_q;
  assign state_d = clr && cnt_q == AW'(DEPTH - 1) ? RUN : state_q;
  assign waddr = bus.regdst ? bus.rd : bus.rt;
  assign w_ok = run && bus.write && in_range(bus.wbank) && !is_zero(bus.wbank, waddr);
  assign c_ok = run && bus.claim && in_range(bus.claim_bank) && !is_zero(bus.claim_bank, bus.claim_addr);
  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    assign we[i] = w_ok && bus.wbank == BW'(i);
    assign ce[i] = c_ok && bus.claim_bank == BW'(i);
    regfile_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk(clk),
      .clr_i(clr),
      .clr_idx_i(cnt_q),
      .we_i(we[i]),
      .waddr_i(waddr),
      .wdata_i(bus.busW),
      .claim_i(ce[i]),
      .claim_addr_i(bus.claim_addr),
      .raddr_a_i(bus.rs),
      .raddr_b_i(bus.rt),
      .rdata_a_o(rdata_a[i]),
      .rdata_b_o(rdata_b[i]),
      .rpend_a_o(rpend_a[i]),
      .rpend_b_o(rpend_b[i])
    );
  end
  // Reads see this edge's write and claim; claim overrides the write's pending clear.
  assign r_ok_a = run && in_range(bus.rbank) && !is_zero(bus.rbank, bus.rs);
  assign r_ok_b = run && in_range(bus.rbank) && !is_zero(bus.rbank, bus.rt);
  assign hit_wa = w_ok && bus.wbank == bus.rbank && waddr == bus.rs;
  assign hit_wb = w_ok && bus.wbank == bus.rbank && waddr == bus.rt;
  assign hit_ca = c_ok && bus.claim_bank == bus.rbank && bus.claim_addr == bus.rs;
  assign hit_cb = c_ok && bus.claim_bank == bus.rbank && bus.claim_addr == bus.rt;
  always_comb begin
    busa_d = !r_ok_a ? '0 : hit_wa ? bus.busW : rdata_a[bus.rbank];
    busb_d = !r_ok_b ? '0 : hit_wb ? bus.busW : rdata_b[bus.rbank];
    penda_d = r_ok_a && (hit_ca || (!hit_wa && rpend_a[bus.rbank]));
    pendb_d = r_ok_b && (hit_cb || (!hit_wb && rpend_b[bus.rbank]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      busa_q <= '0;
      busb_q <= '0;
      penda_q <= 1'b0;
      pendb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busa_q <= busa_d;
      busb_q <= busb_d;
      penda_q <= penda_d;
      pendb_q <= pendb_d;
    end
  end
  assign bus.busA = busa_q;
  assign bus.busB = busb_q;
  assign bus.pendA = penda_q;
  assign bus.pendB = pendb_q;
  assign bus.ready = state_q == RUN;
endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: directed vector table, reset/sweep sequences and random traffic against an array model
module tb_regfile_banked;
  import regfile_pkg::*;
  localparam int W = 32;
  localparam int D = 32;
  localparam int NB = 2;
  localparam int AW = 5;
  localparam int BW = 1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  regfile_banked_if #(.WIDTH(W), .DEPTH(D), .NBANKS(NB)) bus ();
  regfile_banked #(.WIDTH(W), .DEPTH(D), .NBANKS(NB), .ZERO_R0(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [W-1:0] mem [NB][D];
  bit pnd [NB][D];
  int sweep = 0;
  bit mready = 1'b0;
  logic [W-1:0] e_a = '0, e_b = '0;
  bit e_pa = 1'b0, e_pb = 1'b0;
  int nchk = 0, nfail = 0;
  typedef struct {
    bit w, rdst;
    int wb, rb, rd, rs, rt;
    logic [31:0] d;
    bit c;
    int cb, ca;
    logic [31:0] ea, eb;
    bit pa, pb;
  } vec_t;
  vec_t vt [12];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  function automatic bit zr(int b, int a);
    return b == BANK_INT && a == 0;
  endfunction
  function automatic logic [W-1:0] rval(int b, int a);
    return (b >= NB || zr(b, a)) ? '0 : mem[b][a];
  endfunction
  function automatic bit rpnd(int b, int a);
    return (b >= NB || zr(b, a)) ? 1'b0 : pnd[b][a];
  endfunction
  task automatic step_model();
    int wb, wa, cb, ca, rb, rs, rt;
    wb = int'(bus.wbank);
    wa = int'(bus.regdst ? bus.rd : bus.rt);
    cb = int'(bus.claim_bank);
    ca = int'(bus.claim_addr);
    rb = int'(bus.rbank);
    rs = int'(bus.rs);
    rt = int'(bus.rt);
    e_a = '0; e_b = '0; e_pa = 1'b0; e_pb = 1'b0;
    if (rst) begin
      sweep = 0;
      mready = 1'b0;
    end else if (!mready) begin
      sweep++;
      if (sweep == D) begin
        mready = 1'b1;
        for (int b = 0; b < NB; b++)
          for (int a = 0; a < D; a++) begin
            mem[b][a] = '0;
            pnd[b][a] = 1'b0;
          end
      end
    end else begin
      if (bus.write && wb < NB && !zr(wb, wa)) begin
        mem[wb][wa] = bus.busW;
        pnd[wb][wa] = 1'b0;
      end
      if (bus.claim && cb < NB && !zr(cb, ca)) pnd[cb][ca] = 1'b1;
      e_a = rval(rb, rs); e_b = rval(rb, rt);
      e_pa = rpnd(rb, rs); e_pb = rpnd(rb, rt);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    step_model();
    #1;
    chk("busA", bus.busA, e_a);
    chk("busB", bus.busB, e_b);
    chk("pendA", 32'(bus.pendA), 32'(e_pa));
    chk("pendB", 32'(bus.pendB), 32'(e_pb));
    chk("ready", 32'(bus.ready), 32'(mready));
  endtask
  task automatic drive(bit w, bit rdst, int wb, int rb, int rd, int rs, int rt, logic [31:0] d, bit c, int cb, int ca);
    bus.write = w; bus.regdst = rdst;
    bus.wbank = BW'(wb); bus.rbank = BW'(rb);
    bus.rd = AW'(rd); bus.rs = AW'(rs); bus.rt = AW'(rt);
    bus.busW = d; bus.claim = c;
    bus.claim_bank = BW'(cb); bus.claim_addr = AW'(ca);
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
  endtask
  task automatic wait_ready(string n, int want);
    int k = 0;
    while (!bus.ready && k < 100) begin
      cyc();
      k++;
    end
    chk(n, 32'(k), 32'(want));
  endtask
  initial begin
    vt[0]  = '{1, 1, 0, 0, 5, 5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0};
    vt[1]  = '{1, 1, 1, 1, 5, 5, 5, 32'h3F800000, 0, 0, 0, 32'h3F800000, 32'h3F800000, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 5, 5, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vt[3]  = '{1, 0, 0, 0, 9, 7, 7, 32'h12345678, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0};
    vt[4]  = '{1, 1, 0, 0, 0, 0, 7, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 32'h12345678, 0, 0};
    vt[5]  = '{1, 1, 1, 1, 0, 0, 5, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 32'h3F800000, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 0, 3, 0, 32'h0, 1, 1, 3, 32'h0, 32'hFFFFFFFF, 1, 0};
    vt[7]  = '{0, 0, 0, 1, 0, 3, 0, 32'h0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1, 0};
    vt[8]  = '{1, 1, 1, 1, 3, 3, 3, 32'h40000000, 0, 0, 0, 32'h40000000, 32'h40000000, 0, 0};
    vt[9]  = '{1, 1, 1, 1, 3, 3, 3, 32'hC0000000, 1, 1, 3, 32'hC0000000, 32'hC0000000, 1, 1};
    vt[10] = '{0, 0, 0, 1, 0, 3, 5, 32'h0, 0, 0, 0, 32'hC0000000, 32'h3F800000, 1, 0};
    vt[11] = '{1, 0, 1, 1, 3, 3, 4, 32'h11111111, 0, 0, 0, 32'hC0000000, 32'h11111111, 1, 0};
    idle();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    wait_ready("sweep_len", D);
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].w, vt[i].rdst, vt[i].wb, vt[i].rb, vt[i].rd, vt[i].rs, vt[i].rt, vt[i].d, vt[i].c, vt[i].cb, vt[i].ca);
      cyc();
      chk($sformatf("vec%0d_busA", i), bus.busA, vt[i].ea);
      chk($sformatf("vec%0d_busB", i), bus.busB, vt[i].eb);
      chk($sformatf("vec%0d_pendA", i), 32'(bus.pendA), 32'(vt[i].pa));
      chk($sformatf("vec%0d_pendB", i), 32'(bus.pendB), 32'(vt[i].pb));
    end
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_ready("sweep_restart_len", D);
    drive(1, 1, 0, 0, 9, 9, 9, 32'h55, 1, 0, 9);
    cyc();
    chk("r9_run_busA", bus.busA, 32'h55);
    chk("r9_run_pendA", 32'(bus.pendA), 32'd1);
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    drive(1, 1, 0, 0, 9, 9, 9, 32'hAAAA, 1, 0, 9);
    cyc();
    chk("clear_busA_forced", bus.busA, 32'h0);
    idle();
    wait_ready("sweep_tail_len", D - 6);
    drive(0, 0, 0, 0, 0, 9, 9, '0, 0, 0, 0);
    cyc();
    chk("r9_after_clear_busA", bus.busA, 32'h0);
    chk("r9_after_clear_pendA", 32'(bus.pendA), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NB - 1), $urandom_range(0, NB - 1),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom(),
            $urandom_range(0, 3) == 0, $urandom_range(0, NB - 1), $urandom_range(0, 7));
      rst = $urandom_range(0, 399) == 0;
      cyc();
    end
    rst = 1'b0;
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/regfile_banked.md
# regfile_banked

Parametrised multi-bank register file: the next generation of the single-cycle datapath's integer/floating-point register file. It provides NBANKS banks of DEPTH x WIDTH registers, two registered read ports with write-through bypass, and one write port with rd/rt destination select. It adds a per-register pending (scoreboard) bit for multi-cycle producers and a post-reset clear sweep with a `ready` output. It sits between decode and the ALU/FPU operand latches.

## Interface
- WIDTH, 32, data width of every register
- DEPTH, 32, registers per bank (power of two, >= 2); AW = $clog2(DEPTH)
- NBANKS, 2, number of banks (bank 0 integer, bank 1 FP); BW = max(1, $clog2(NBANKS))
- ZERO_R0, 1, when 1, bank 0 register 0 reads as zero, ignores writes, and is never pending
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- write  in  1  write enable
- regdst  in  1  write address select: 0 uses rt, 1 uses rd
- wbank  in  BW  bank of the write
- rbank  in  BW  bank of both reads
- rd, rs, rt  in  AW each  destination and source register numbers
- busW  in  WIDTH  write data
- claim  in  1  mark register (claim_bank, claim_addr) pending
- claim_bank  in  BW  bank to claim
- claim_addr  in  AW  register to claim
- busA, busB  out  WIDTH  registered read data for rs, rt
- pendA, pendB  out  1  registered pending flags for rs, rt
- ready  out  1  high once the clear sweep is complete

## Operation
- States: CLEAR, RUN.
- rst=1 at an edge: state becomes CLEAR and the sweep counter is set to 0. A reset during CLEAR restarts the sweep at 0. A reset during RUN abandons all state.
- CLEAR: each cycle zeroes entry[counter] and pend[counter] in every bank, then increments the counter. After the edge that clears entry DEPTH-1, state becomes RUN. The sweep takes exactly DEPTH cycles after rst deasserts.
- During CLEAR, write and claim are ignored, and busA, busB, pendA and pendB are forced to 0.
- RUN write: waddr = regdst ? rd : rt. If write=1, entry[wbank][waddr] <= busW and pend[wbank][waddr] <= 0.
- RUN claim: if claim=1, pend[claim_bank][claim_addr] <= 1. When claim and write target the same register on the same edge, claim wins: the data is written and pending ends at 1.
- Reads: busA <= value of entry[rbank][rs] after this edge's write (write-through bypass when write hits rbank/rs). busB is the same for rt. pendA and pendB take the post-update pending bit the same way, so a simultaneous claim is visible.
- ZERO_R0=1: bank 0 address 0 always reads 0 with pending 0. Writes and claims to it are dropped.
- Out-of-range bank numbers (NBANKS not a power of two): writes and claims are dropped, and reads return 0 with pending 0.

## Timing
- Reset values: busA=0, busB=0, pendA=0, pendB=0, ready=0.
- ready rises on the edge that enters RUN, which is DEPTH edges after the first edge with rst=0.
- Read latency is 1 cycle: addresses sampled at edge N appear on busA/busB after edge N.
- Write-to-read latency is 0 extra cycles because of the bypass. A write at edge N is visible on a read sampled at edge N.
- Claim-to-pend latency and write-clears-pend latency are both 1 edge, with the same bypass rule.
- No combinational path from inputs to outputs.

## Structure
- Package regfile_pkg holds:
  - the state enum {CLEAR, RUN}
  - constants BANK_INT=0 and BANK_FP=1
  - a helper function for the BW calculation
- Sub-module regfile_bank is instanced NBANKS times. It holds the DEPTH x WIDTH storage and DEPTH pending bits, takes a clear index plus write and claim strobes, and provides two combinational read ports.
- The top level holds the sweep FSM and counter, bank decode, bypass, the ZERO_R0 mask, and the output registers.

## Test plan
- Reset sweep: hold rst 3 cycles, release. ready must stay 0 for exactly 32 cycles then go to 1, and busA/busB must read 0 throughout. Pulse rst at sweep cycle 10: ready must be delayed a full 32 cycles from that release.
- Basic bank separation: write int r5=0xDEADBEEF (regdst=1, rd=5) and FP r5=0x3F800000. Read rbank=0 rs=5 gives busA=0xDEADBEEF; rbank=1 gives 0x3F800000.
- Bypass: on the same edge, write int r7=0x12345678 and read rs=7, rt=7. Next cycle busA=busB=0x12345678, not the old value 0.
- Zero register: write int r0=0xFFFFFFFF and claim int r0. Read gives busA=0 and pendA=0. FP r0 written with 0xFFFFFFFF reads back 0xFFFFFFFF.
- Scoreboard: claim FP r3, then read the next cycle: pendA=1. Write FP r3=0x40000000: pendA=0 and busA=0x40000000. Claim plus write to r3 on the same edge: busA=new data and pendA=1.
- Writes and claims during CLEAR: assert write to int r9=0xAAAA and claim r9 mid-sweep. After ready, r9 reads 0 with pend 0.
